if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32 pipeline: owns the PC, drives the I-cache read port, and holds the IF/ID pipeline register feeding decode. It consumes the decode-stage hazard stall and the ID-resolved branch/jump redirect. It tolerates multi-cycle I-cache misses, including a redirect that arrives while a miss is outstanding, and freezes on D-cache stalls.

---
 rtl/if_fetch_stage_pkg.sv | 23 ++
 rtl/if_fetch_stage_if.sv | 32 +++
 rtl/ifid_pipe_reg.sv | 38 +++
 rtl/if_fetch_stage.sv | 87 ++++++++
 tb/tb_if_fetch_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions: NOP encoding, IF/ID bundle, default reset PC.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WADDR_W    = 30;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifid_t;

    // IF/ID update selector
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_ctrl_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect/freeze from the pipeline, I-cache read
// port, and the IF/ID outputs to decode.
//   master: the fetch stage (drives ICACHE_ren/addr and IFID_*)
//   slave : the surrounding pipeline and I-cache
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic               hazard_stall;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               DCACHE_stall;
    logic               ICACHE_stall;
    logic [XLEN-1:0]    ICACHE_rdata;
    logic               ICACHE_ren;
    logic [WADDR_W-1:0] ICACHE_addr;
    logic [XLEN-1:0]    IFID_pc;
    logic [XLEN-1:0]    IFID_inst;
    logic               IFID_valid;

    modport master (
        input  hazard_stall, redirect, redirect_pc, DCACHE_stall,
               ICACHE_stall, ICACHE_rdata,
        output ICACHE_ren, ICACHE_addr, IFID_pc, IFID_inst, IFID_valid
    );

    modport slave (
        output hazard_stall, redirect, redirect_pc, DCACHE_stall,
               ICACHE_stall, ICACHE_rdata,
        input  ICACHE_ren, ICACHE_addr, IFID_pc, IFID_inst, IFID_valid
    );

endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with hold / bubble / load control.
// Ports: clk, rst_n (async active-low), ctrl (ifid_ctrl_e), pc_i, inst_i,
//        ifid_o (registered IF/ID bundle).
module ifid_pipe_reg
    import if_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  ifid_ctrl_e      ctrl,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output ifid_t           ifid_o
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    // Next-state select; bubbles carry NOP so decode needs no valid gating
    always_comb begin
        ifid_d = ifid_q;
        case (ctrl)
            IFID_BUBBLE: ifid_d = '{pc: pc_i, inst: NOP_INST, valid: 1'b0};
            IFID_LOAD:   ifid_d = '{pc: pc_i, inst: inst_i,   valid: 1'b1};
            default:     ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC and the pending-redirect register,
// drives the I-cache read port and feeds the IF/ID register.
// Ports: clk, rst_n (async active-low), fb (if_fetch_stage_if.master):
//   in : hazard_stall, redirect, redirect_pc, DCACHE_stall, ICACHE_stall, ICACHE_rdata
//   out: ICACHE_ren (= rst_n), ICACHE_addr (= PC[31:2]), IFID_pc/inst/valid
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_fetch_stage_if.master      fb
);

    logic [XLEN-1:0] pc_q,       pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_pc_q,  pend_pc_d;
    ifid_ctrl_e      ifid_ctrl;
    ifid_t           ifid;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = {fb.redirect_pc[XLEN-1:2], 2'b00};

    // Priority: D-cache freeze > I-cache miss > hazard > redirect > pending redirect > advance
    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        ifid_ctrl    = IFID_HOLD;

        if (fb.DCACHE_stall) begin
            // ID is frozen and will re-present any redirect
        end else if (fb.ICACHE_stall) begin
            // Address must stay put until the miss returns; remember the redirect
            if (!fb.hazard_stall) begin
                ifid_ctrl = IFID_BUBBLE;
                if (fb.redirect) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_tgt;
                end
            end
        end else if (fb.hazard_stall) begin
            // Fetched word is dropped and re-read next cycle
        end else if (fb.redirect) begin
            pc_d         = redirect_tgt;
            ifid_ctrl    = IFID_BUBBLE;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            // Returned word belongs to the old path
            pc_d         = pend_pc_q;
            ifid_ctrl    = IFID_BUBBLE;
            pend_valid_d = 1'b0;
        end else begin
            pc_d      = pc_q + XLEN'(4);
            ifid_ctrl = IFID_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    ifid_pipe_reg u_ifid (
        .clk    (clk),
        .rst_n  (rst_n),
        .ctrl   (ifid_ctrl),
        .pc_i   (pc_q),
        .inst_i (fb.ICACHE_rdata),
        .ifid_o (ifid)
    );

    assign fb.ICACHE_ren  = rst_n;
    assign fb.ICACHE_addr = pc_q[XLEN-1:2];
    assign fb.IFID_pc     = ifid.pc;
    assign fb.IFID_inst   = ifid.inst;
    assign fb.IFID_valid  = ifid.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus pushes expected per-cycle outputs
// from a behavioural pipeline model; a negedge monitor pops and compares.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (bus.master)
    );

    // I-cache contents: an address-dependent pattern
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return (32'h9E37_79B9 * {2'b00, a}) ^ 32'h1234_5678;
    endfunction

    assign bus.ICACHE_rdata = bus.ICACHE_stall ? 32'hDEAD_BEEF : mem_word(bus.ICACHE_addr);

    typedef struct {
        logic [29:0] addr;
        logic        ren;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pend_pc, m_if_pc, m_if_inst;
    logic        m_pend, m_if_valid;

    function automatic void model_reset();
        m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0;
        m_if_pc = 32'h0; m_if_inst = NOP_INST; m_if_valid = 1'b0;
    endfunction

    function automatic void set_bubble();
        m_if_pc = m_pc; m_if_inst = NOP_INST; m_if_valid = 1'b0;
    endfunction

    function automatic void model_step(input logic rst, hz, rd, input logic [31:0] rpc,
                                       input logic dc, ic);
        logic [31:0] tgt;
        tgt = rpc & 32'hFFFF_FFFC;
        if (!rst) begin
            model_reset();
        end else if (dc) begin
            // frozen
        end else if (ic) begin
            if (!hz) begin
                set_bubble();
                if (rd) begin m_pend = 1'b1; m_pend_pc = tgt; end
            end
        end else if (hz) begin
            // stalled by decode
        end else if (rd) begin
            set_bubble(); m_pc = tgt; m_pend = 1'b0;
        end else if (m_pend) begin
            set_bubble(); m_pc = m_pend_pc; m_pend = 1'b0;
        end else begin
            m_if_pc = m_pc; m_if_inst = mem_word(m_pc[31:2]); m_if_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        vectors++;
        if (act !== exv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
        end
    endfunction

    // One pipeline cycle: drive inputs, record expected outputs, advance model
    task automatic cycle(input logic rst, hz, rd, input logic [31:0] rpc, input logic dc, ic);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        bus.hazard_stall = hz;
        bus.redirect = rd;
        bus.redirect_pc = rpc;
        bus.DCACHE_stall = dc;
        bus.ICACHE_stall = ic;
        if (!rst) model_reset();
        e.addr = m_pc[31:2]; e.ren = rst;
        e.pc = m_if_pc; e.inst = m_if_inst; e.valid = m_if_valid;
        exp_q.push_back(e);
        model_step(rst, hz, rd, rpc, dc, ic);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'h0, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ICACHE_addr", 32'(bus.ICACHE_addr), 32'(e.addr));
                chk("ICACHE_ren",  32'(bus.ICACHE_ren),  32'(e.ren));
                chk("IFID_pc",     bus.IFID_pc,          e.pc);
                chk("IFID_inst",   bus.IFID_inst,        e.inst);
                chk("IFID_valid",  32'(bus.IFID_valid),  32'(e.valid));
            end
        end
    end

    initial begin
        int guard;
        bus.hazard_stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
        bus.DCACHE_stall = 0; bus.ICACHE_stall = 0;
        model_reset();
        #1 rst_n = 1'b0;

        cycle(0, 0, 0, 32'h0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0);
        // Sequential hits from RESET_PC
        hits(3);
        // Decode hazard for two cycles
        cycle(1, 1, 0, 32'h0, 0, 0);
        cycle(1, 1, 0, 32'h0, 0, 0);
        hits(2);
        // Redirect with no miss
        cycle(1, 0, 1, 32'h0000_0100, 0, 0);
        hits(3);
        // Four-cycle miss with redirect in its second cycle
        cycle(1, 0, 0, 32'h0, 0, 1);
        cycle(1, 0, 1, 32'h0000_0200, 0, 1);
        cycle(1, 0, 0, 32'h0, 0, 1);
        cycle(1, 0, 0, 32'h0, 0, 1);
        hits(4);
        // D-cache freeze with toggling redirect / hazard, including during a pending redirect
        cycle(1, 0, 1, 32'h0000_0300, 0, 1);
        cycle(1, 0, 1, 32'h0000_0404, 1, 0);
        cycle(1, 1, 0, 32'h0000_0508, 1, 1);
        cycle(1, 0, 1, 32'h0000_060C, 1, 0);
        hits(3);
        // Hazard and redirect together: stall wins
        cycle(1, 1, 1, 32'h0000_0700, 0, 0);
        hits(2);
        // Reset mid-miss with a pending redirect
        cycle(1, 0, 0, 32'h0, 0, 1);
        cycle(1, 0, 1, 32'h0000_0800, 0, 1);
        cycle(0, 0, 0, 32'h0, 0, 1);
        hits(3);
        // Unaligned redirect target near top of address space; PC wraps
        cycle(1, 0, 1, 32'hFFFF_FFFB, 0, 0);
        hits(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 6) == 0),
                  $urandom(),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) == 0));
        end
        hits(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
